// File: rtl/logic_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pkg
// Description : Shared types and constants for the Tomasulo logic unit.
//               Defines the op encodings, the default widths, the null tag,
//               the reservation-station entry state and the entry record.
// Revision    : 1.0 - initial release
// ============================================================================
package logic_unit_pkg;

    localparam int RS_DATA_W = 32;
    localparam int RS_TAG_W  = 4;

    // A zero tag means the operand value is already held in the entry.
    localparam logic [RS_TAG_W-1:0] NULL_TAG = '0;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOT = 2'b11;

    typedef enum logic [1:0] {
        RS_FREE = 2'd0,
        RS_WAIT = 2'd1,
        RS_RDY  = 2'd2
    } rs_state_t;

    typedef struct packed {
        rs_state_t              state;
        logic [1:0]             op;
        logic [RS_TAG_W-1:0]    dest;
        logic [RS_TAG_W-1:0]    qj;
        logic [RS_DATA_W-1:0]   vj;
        logic [RS_TAG_W-1:0]    qk;
        logic [RS_DATA_W-1:0]   vk;
    } rs_entry_t;

endpackage
`default_nettype wire

// File: rtl/logic_alu32.sv
`default_nettype none
// ============================================================================
// Module      : logic_alu32
// Description : Purely combinational bitwise ALU: AND / OR / XOR / NOT.
//               NOT inverts the J operand and ignores K.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_alu32
    import logic_unit_pkg::*;
#(
    parameter int DATA_W = RS_DATA_W
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] vj,
    input  logic [DATA_W-1:0] vk,
    output logic [DATA_W-1:0] result
);

    // Select the bitwise function requested by the op code.
    always_comb begin
        result = '0;
        case (op)
            LOP_AND: result = vj & vk;
            LOP_OR:  result = vj | vk;
            LOP_XOR: result = vj ^ vk;
            default: result = ~vj;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/logic_rs_exec.sv
`default_nettype none
// ============================================================================
// Module      : logic_rs_exec
// Description : Reservation station plus single-stage execute for the logic
//               functional unit. Holds issued instructions until both
//               operands arrive (issue-time forwarding and CDB snoop), then
//               dispatches one ready entry per cycle through logic_alu32 into
//               a result register that is held until the CDB grants it.
//               Optional: define LOGIC_RS_AGE_ORDER_EN to dispatch the oldest
//               ready entry (age matrix) instead of the lowest-index one.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_rs_exec
    import logic_unit_pkg::*;
#(
    parameter int NUM_ENTRIES = 4,
    parameter int TAG_W       = RS_TAG_W,
    parameter int DATA_W      = RS_DATA_W
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               flush,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    input  logic [1:0]                         issue_op,
    input  logic [TAG_W-1:0]                   issue_dest,
    input  logic [TAG_W-1:0]                   issue_qj,
    input  logic [TAG_W-1:0]                   issue_qk,
    input  logic [DATA_W-1:0]                  issue_vj,
    input  logic [DATA_W-1:0]                  issue_vk,
    input  logic                               cdb_in_valid,
    input  logic [TAG_W-1:0]                   cdb_in_tag,
    input  logic [DATA_W-1:0]                  cdb_in_data,
    output logic                               cdb_out_valid,
    output logic [TAG_W-1:0]                   cdb_out_tag,
    output logic [DATA_W-1:0]                  cdb_out_data,
    input  logic                               cdb_out_grant,
    output logic [$clog2(NUM_ENTRIES+1)-1:0]   busy_count
);

    localparam int c_idx_w = $clog2(NUM_ENTRIES);
    localparam int c_cnt_w = $clog2(NUM_ENTRIES+1);

    rs_entry_t                r_ent     [NUM_ENTRIES];
    rs_entry_t                w_ent_nxt [NUM_ENTRIES];
    rs_entry_t                w_new_ent;

    logic [NUM_ENTRIES-1:0]   w_rdy_vec;
    logic [c_idx_w-1:0]       w_alloc_idx;
    logic [c_idx_w-1:0]       w_disp_idx;
    logic                     w_any_free;
    logic                     w_any_rdy;
    logic                     w_issue;
    logic                     w_dispatch;
    logic                     w_cdb_hit;
    logic [DATA_W-1:0]        w_alu_result;
    logic [c_cnt_w-1:0]       w_busy_nxt;

    logic                     r_out_valid;
    logic [TAG_W-1:0]         r_out_tag;
    logic [DATA_W-1:0]        r_out_data;
    logic [c_cnt_w-1:0]       r_busy;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_rdy
        assign w_rdy_vec[g] = (r_ent[g].state == RS_RDY);
    end

    // A broadcast with the null tag carries nothing an entry can wait on.
    assign w_cdb_hit  = cdb_in_valid && (cdb_in_tag != NULL_TAG);
    // The result register can take a new result when empty or when its
    // current contents leave this cycle.
    assign w_issue    = issue_valid && w_any_free && !flush;
    assign w_dispatch = w_any_rdy && (!r_out_valid || cdb_out_grant) && !flush;

    assign issue_ready   = w_any_free;
    assign cdb_out_valid = r_out_valid;
    assign cdb_out_tag   = r_out_tag;
    assign cdb_out_data  = r_out_data;
    assign busy_count    = r_busy;

`ifdef LOGIC_RS_AGE_ORDER_EN
    // r_age[i][j] set means entry i was issued before entry j.
    logic [NUM_ENTRIES-1:0]   r_age [NUM_ENTRIES];
    logic                     w_blocked;

    // A newly allocated entry is younger than every other entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else if (w_issue) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (c_idx_w'(i) == w_alloc_idx) begin
                    r_age[i] <= '0;
                end else begin
                    r_age[i][w_alloc_idx] <= 1'b1;
                end
            end
        end
    end
`endif

    // Output decode: lowest free slot for allocation, dispatch selection.
    always_comb begin
        w_any_free  = 1'b0;
        w_alloc_idx = '0;
        w_any_rdy   = 1'b0;
        w_disp_idx  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (r_ent[i].state == RS_FREE) begin
                w_any_free  = 1'b1;
                w_alloc_idx = c_idx_w'(i);
            end
        end
`ifdef LOGIC_RS_AGE_ORDER_EN
        w_blocked = 1'b0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_blocked = 1'b0;
            for (int j = 0; j < NUM_ENTRIES; j++) begin
                if (w_rdy_vec[j] && r_age[j][i]) begin
                    w_blocked = 1'b1;
                end
            end
            if (w_rdy_vec[i] && !w_blocked) begin
                w_any_rdy  = 1'b1;
                w_disp_idx = c_idx_w'(i);
            end
        end
`else
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_rdy_vec[i]) begin
                w_any_rdy  = 1'b1;
                w_disp_idx = c_idx_w'(i);
            end
        end
`endif
    end

    // Build the entry for an incoming issue, forwarding a same-cycle
    // broadcast into any outstanding operand. NOT never waits on K.
    always_comb begin
        w_new_ent      = '0;
        w_new_ent.op   = issue_op;
        w_new_ent.dest = issue_dest;
        if (issue_qj == NULL_TAG) begin
            w_new_ent.vj = issue_vj;
        end else if (cdb_in_valid && (cdb_in_tag == issue_qj)) begin
            w_new_ent.vj = cdb_in_data;
        end else begin
            w_new_ent.qj = issue_qj;
        end
        if (issue_op != LOP_NOT) begin
            if (issue_qk == NULL_TAG) begin
                w_new_ent.vk = issue_vk;
            end else if (cdb_in_valid && (cdb_in_tag == issue_qk)) begin
                w_new_ent.vk = cdb_in_data;
            end else begin
                w_new_ent.qk = issue_qk;
            end
        end
        w_new_ent.state = ((w_new_ent.qj == NULL_TAG) && (w_new_ent.qk == NULL_TAG))
                          ? RS_RDY : RS_WAIT;
    end

    // Next-state for every entry: snoop, dispatch release, allocation, flush.
    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_ent_nxt[i] = r_ent[i];
            if ((r_ent[i].state == RS_WAIT) && w_cdb_hit) begin
                if (r_ent[i].qj == cdb_in_tag) begin
                    w_ent_nxt[i].qj = NULL_TAG;
                    w_ent_nxt[i].vj = cdb_in_data;
                end
                if (r_ent[i].qk == cdb_in_tag) begin
                    w_ent_nxt[i].qk = NULL_TAG;
                    w_ent_nxt[i].vk = cdb_in_data;
                end
                if ((w_ent_nxt[i].qj == NULL_TAG) && (w_ent_nxt[i].qk == NULL_TAG)) begin
                    w_ent_nxt[i].state = RS_RDY;
                end
            end
            if (w_dispatch && (w_disp_idx == c_idx_w'(i))) begin
                w_ent_nxt[i].state = RS_FREE;
            end
            if (w_issue && (w_alloc_idx == c_idx_w'(i))) begin
                w_ent_nxt[i] = w_new_ent;
            end
            if (flush) begin
                w_ent_nxt[i].state = RS_FREE;
            end
        end
    end

    // Occupancy after this edge, registered into busy_count.
    always_comb begin
        w_busy_nxt = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_ent_nxt[i].state != RS_FREE) begin
                w_busy_nxt = w_busy_nxt + c_cnt_w'(1);
            end
        end
    end

    // Entry state register and occupancy counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_ent[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_ent[i] <= w_ent_nxt[i];
            end
            r_busy <= w_busy_nxt;
        end
    end

    logic_alu32 #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op     (r_ent[w_disp_idx].op),
        .vj     (r_ent[w_disp_idx].vj),
        .vk     (r_ent[w_disp_idx].vk),
        .result (w_alu_result)
    );

    // Result register: held until granted; flush wins over grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else if (w_dispatch) begin
            r_out_valid <= 1'b1;
            r_out_tag   <= r_ent[w_disp_idx].dest;
            r_out_data  <= w_alu_result;
        end else if (cdb_out_grant) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/logic_rs_exec.md
Name: logic_rs_exec

Overview:
Reservation station plus single-stage execute for the Tomasulo logic functional unit. It accepts issued AND/OR/XOR/NOT instructions and holds them until both operands are available, capturing operands from the common data bus (CDB). It then dispatches ready instructions to a combinational 32-bit logic ALU and broadcasts registered results on the CDB through a valid/grant handshake.

Parameters:
NUM_ENTRIES, 4, number of reservation-station slots (2..8)
TAG_W, 4, ROB/RS tag width; tag value 0 means "operand value present"
DATA_W, 32, operand/result width

Ports:
CLK  input  1  single clock, rising edge
RSTN  input  1  asynchronous active-low reset
FLUSH  input  1  synchronous squash of all entries and output register
ISSUE_VALID  input  1  issue request
ISSUE_READY  output  1  at least one free entry
ISSUE_OP  input  2  00 AND, 01 OR, 10 XOR, 11 NOT (uses J only)
ISSUE_DEST  input  TAG_W  destination tag, nonzero
ISSUE_QJ / ISSUE_QK  input  TAG_W  producer tags, 0 = value valid
ISSUE_VJ / ISSUE_VK  input  DATA_W  operand values when Q=0
CDB_IN_VALID  input  1  broadcast valid
CDB_IN_TAG  input  TAG_W  broadcast tag
CDB_IN_DATA  input  DATA_W  broadcast value
CDB_OUT_VALID  output  1  result pending
CDB_OUT_TAG  output  TAG_W  result tag
CDB_OUT_DATA  output  DATA_W  result value
CDB_OUT_GRANT  input  1  arbiter accepts result this cycle
BUSY_COUNT  output  $clog2(NUM_ENTRIES+1)  occupied entries

Behaviour:
- Reset (RSTN low, async): all entries FREE. CDB_OUT_VALID=0, CDB_OUT_TAG=0, CDB_OUT_DATA=0, BUSY_COUNT=0. ISSUE_READY=1 after release.
- Entry states: FREE -> WAIT (issue, an operand outstanding) -> RDY (both operands present) -> FREE (dispatch). An issue whose operands are both present goes FREE -> RDY directly.
- Issue fires on ISSUE_VALID && ISSUE_READY. The lowest-index FREE entry is allocated. ISSUE_READY is combinational from entry state only.
- Issue-time forwarding: if CDB_IN_VALID and CDB_IN_TAG equals a nonzero ISSUE_QJ/QK in the same cycle, CDB_IN_DATA is captured and the Q field stored as 0.
- Snoop: every WAIT entry whose Qj/Qk equals CDB_IN_TAG (valid, nonzero) captures the data and clears Q. Entries may capture J and K on the same broadcast.
- NOT: the K operand is treated as present regardless of ISSUE_QK. Result = ~Vj.
- Dispatch: one RDY entry per cycle, lowest index by default. Dispatch is allowed when the output register is empty or is being granted this cycle, which gives back-to-back throughput of 1/cycle. An entry that becomes RDY via snoop in cycle t is dispatchable in t+1.
- Latency: issue with ready operands at t -> CDB_OUT_VALID at t+2. A CDB capture at t -> CDB_OUT_VALID at t+2.
- Output hold: CDB_OUT_VALID/TAG/DATA stay stable until CDB_OUT_GRANT. GRANT while VALID=0 is ignored.
- Full: ISSUE_READY=0. An entry freed by dispatch in cycle t is allocatable in t+1, not t.
- FLUSH: all entries FREE and CDB_OUT_VALID=0 on the next edge. Issue and dispatch in the same cycle are discarded. FLUSH takes priority over GRANT.
- BUSY_COUNT = number of non-FREE entries, registered.

Optional Feature:
LOGIC_RS_AGE_ORDER_EN
- Defined: an NUM_ENTRIES x NUM_ENTRIES age matrix is maintained and dispatch selects the oldest RDY entry.
- Undefined: lowest-index RDY entry, with no age storage.
- Either way, each entry dispatches exactly once.

Decomposition:
- Package logic_unit_pkg: op encodings (LOP_AND/OR/XOR/NOT), DATA_W/TAG_W defaults, NULL_TAG=0, rs_entry_t struct (state, op, dest, qj, vj, qk, vk).
- Sub-module logic_alu32: purely combinational op/Vj/Vk -> result, instantiated once at dispatch.

Test Plan:
- Issue AND dest=3, VJ=F0F0F0F0, VK=FF00FF00, Q=0 at t0 -> CDB_OUT_VALID t2, TAG=3, DATA=F000F000.
- Issue NOT dest=5, QJ=7, ISSUE_QK=2; CDB tag7 data=0000FFFF at t3 -> result FFFF0000 at t5. Tag 2 is never needed.
- Same-cycle issue QJ=4 with CDB tag4=12345678, XOR VK=FFFFFFFF -> captured, result EDCBA987 two cycles later.
- Fill all 4 entries waiting on tag 9, hold GRANT=0 -> ISSUE_READY=0. Then broadcast tag 9 -> one result per cycle once GRANT=1, in index order, or issue order with LOGIC_RS_AGE_ORDER_EN.
- Result pending, GRANT low 3 cycles -> VALID/TAG/DATA unchanged. GRANT pulse -> next result follows in the very next cycle.
- Assert FLUSH with 3 busy entries and a pending output -> BUSY_COUNT=0 and VALID=0 next cycle. Async RSTN mid-operation clears all outputs immediately.
